vec_result_writer: RTL and testbench
====================================

// Module: vec_result_writer
// PURPOSE
//  Write-back end of the vector ALU datapath. Accepts one full result vector
//  (VECTOR_SIZE bits, ELEMENT-bit lanes) through a valid/ready handshake and
//  stores it lane by lane into ELEMENT-wide, word-addressed data memory.
//  It sits between the vector ALU result bus and the data-memory write port.
// PARAMETERS
//  VECTOR_SIZE  256  total vector width in bits; must be a multiple of ELEMENT
//  ELEMENT      16   lane width in bits; also the memory word width
//  ADDR_W       16   memory word-address width
//  (derived) NUM_EL = VECTOR_SIZE/ELEMENT (16 at defaults); IDX_W = clog2(NUM_EL)
// PORTS
//  clk          in   1            single clock; all state changes on posedge
//  rst          in   1            synchronous, active-high reset
//  in_valid     in   1            a result vector is offered
//  in_ready     out  1            the block can accept a vector this cycle
//  in_vector    in   VECTOR_SIZE  result vector; lane i = bits [i*ELEMENT +: ELEMENT]
//  in_base_addr in   ADDR_W       word address for lane 0
//  mem_we       out  1            write request to memory
//  mem_addr     out  ADDR_W       write word address
//  mem_wdata    out  ELEMENT      write data
//  mem_ack      in   1            memory accepts the current write this cycle
//  done         out  1            one-cycle pulse: vector fully stored
// BEHAVIOUR
//  - Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0,
//    state=IDLE, idx=0. All outputs are registered.
//  - FSM states: IDLE, WRITE, DONE.
//  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_vector and
//    in_base_addr, set idx=0, go to WRITE. No capture without in_valid.
//  - WRITE: in_ready=0, mem_we=1, mem_addr=base+idx (mod 2^ADDR_W),
//    mem_wdata=lane idx. Outputs hold stable until mem_ack is sampled high.
//    On ack: if idx==NUM_EL-1 go to DONE, else idx+1.
//  - DONE: done=1 and mem_we=0 for exactly one cycle, in_ready=0;
//    then go to IDLE.
//  - Lane order is ascending: lane 0 (LSBs) first.
//  - Address wraps silently past 2^ADDR_W-1 to 0. No error flag.
//  - Latency with mem_ack held 1: accept at edge 0, writes in cycles 1..NUM_EL,
//    done in cycle NUM_EL+1, next accept possible in cycle NUM_EL+2.
//    Each cycle mem_ack is low adds one cycle.
//  - in_valid while busy is ignored; the sender holds the vector until in_ready.
//  - mem_ack outside WRITE is ignored.
//  - rst during WRITE or DONE aborts at that edge: all outputs take reset values,
//    done does not pulse, and lanes already written are not undone.
// CONFIGURATION
//  VEC_WB_MASK_EN defined: adds input in_mask [NUM_EL-1:0], captured with
//    in_vector. A lane with mask bit 0 spends one WRITE cycle with mem_we=0,
//    does not wait for mem_ack, and idx still advances.
//    Lane addresses are unchanged by masking.
//  VEC_WB_MASK_EN undefined: no in_mask port, and every lane is written.
// TESTING
//  1 rst high 2 cycles -> in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0.
//  2 lane i=16'h0100+i, base=16'h0040, mem_ack=1 -> 16 writes on consecutive
//    cycles, addr 0x0040..0x004F, data 0x0100..0x010F, done in cycle 17,
//    in_ready=1 in cycle 18.
//  3 as test 2, but mem_ack low 3 cycles at lane 5 -> addr 0x0045/data 0x0105
//    held stable for 4 cycles, no lane skipped or repeated, done in cycle 20.
//  4 base=16'hFFF8 -> addresses FFF8..FFFF then 0000..0007, done once.
//  5 rst asserted after the 4th ack -> next cycle mem_we=0, in_ready=1, no
//    done pulse; a new vector is then accepted and stored correctly.
//  6 (VEC_WB_MASK_EN) mask=16'h00FF -> writes only lanes 0..7; done in cycle 17.
//    mask=0 -> no mem_we, done in cycle 17.

Source files
------------

// File: rtl/vec_result_writer.sv
// Vector result write-back: stores one result vector lane by lane into memory.
// Optional per-lane write mask enabled with `define VEC_WB_MASK_EN.
module vec_result_writer #(
  parameter int VECTOR_SIZE = 256,
  parameter int ELEMENT     = 16,
  parameter int ADDR_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [VECTOR_SIZE-1:0]            in_vector,
  input  logic [ADDR_W-1:0]                 in_base_addr,
`ifdef VEC_WB_MASK_EN
  input  logic [VECTOR_SIZE/ELEMENT-1:0]    in_mask,
`endif
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [ELEMENT-1:0]                mem_wdata,
  input  logic                              mem_ack,
  output logic                              done
);

  localparam int NUM_EL = VECTOR_SIZE / ELEMENT;
  localparam int IDX_W  = (NUM_EL > 1) ? $clog2(NUM_EL) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_EL - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [VECTOR_SIZE-1:0] vec_q, vec_d;
  logic [ADDR_W-1:0]      base_q, base_d;

  logic                   ready_q, ready_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ELEMENT-1:0]     wdata_q, wdata_d;
  logic                   done_q, done_d;

  logic [IDX_W-1:0]       idx_nx;
  logic [ELEMENT-1:0]     lane [NUM_EL];
  logic                   en_first;
  logic                   en_cur;
  logic                   en_next;
  logic                   advance;

  // Slice the captured vector into addressable lanes
  for (genvar g = 0; g < NUM_EL; g++) begin : g_lane
    assign lane[g] = vec_q[g*ELEMENT +: ELEMENT];
  end

  assign idx_nx = idx_q + 1'b1;

`ifdef VEC_WB_MASK_EN
  logic [NUM_EL-1:0] mask_q, mask_d;

  // Lane mask captured alongside the vector
  always_ff @(posedge clk) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  // Masked-off lanes spend a cycle without a write request
  always_comb begin
    mask_d = mask_q;
    if (state_q == IDLE && in_valid && ready_q) mask_d = in_mask;
  end

  assign en_first = in_mask[0];
  assign en_cur   = mask_q[idx_q];
  assign en_next  = mask_q[idx_nx];
`else
  assign en_first = 1'b1;
  assign en_cur   = 1'b1;
  assign en_next  = 1'b1;
`endif

  // A disabled lane advances without waiting for the memory
  assign advance = en_cur ? mem_ack : 1'b1;

  // State, capture registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      base_q  <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      base_q  <= base_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle early
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    base_d  = base_q;
    ready_d = ready_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        we_d    = 1'b0;
        if (in_valid && ready_q) begin
          vec_d   = in_vector;
          base_d  = in_base_addr;
          idx_d   = '0;
          state_d = WRITE;
          ready_d = 1'b0;
          we_d    = en_first;
          addr_d  = in_base_addr;
          wdata_d = in_vector[ELEMENT-1:0];
        end
      end
      WRITE: begin
        ready_d = 1'b0;
        if (advance) begin
          if (idx_q == LAST) begin
            state_d = DONE;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_nx;
            we_d    = en_next;
            addr_d  = base_q + ADDR_W'(idx_nx);
            wdata_d = lane[idx_nx];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        we_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        we_d    = 1'b0;
      end
    endcase
  end

  assign in_ready  = ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vec_result_writer.sv
// Bench for vec_result_writer: directed and random vectors against a
// lane-sequence reference model with randomized memory stalls.
module tb_vec_result_writer;

  localparam int VS = 256;
  localparam int E  = 16;
  localparam int NE = VS / E;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VS-1:0] in_vector;
  logic [AW-1:0] in_base_addr;
`ifdef VEC_WB_MASK_EN
  logic [NE-1:0] in_mask;
`endif
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [E-1:0]  mem_wdata;
  logic          mem_ack;
  logic          done;

  int n_chk  = 0;
  int n_fail = 0;
  int st [NE];

  vec_result_writer #(
    .VECTOR_SIZE(VS),
    .ELEMENT(E),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_vector(in_vector),
    .in_base_addr(in_base_addr),
`ifdef VEC_WB_MASK_EN
    .in_mask(in_mask),
`endif
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VS-1:0] rand_vec();
    logic [VS-1:0] v;
    for (int i = 0; i < VS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_stalls();
    for (int i = 0; i < NE; i++) st[i] = 0;
  endtask

  // Send one vector, then follow the expected write sequence cycle by cycle.
  // st[i] = cycles mem_ack stays low before lane i is acked.
  // abort_after > 0 asserts rst one cycle after that many acks.
  task automatic xfer(input logic [VS-1:0] v, input logic [AW-1:0] b,
                      input logic [NE-1:0] m, input int abort_after);
    int li, sl, cyc, acks, budget, exp_done;
    logic [AW-1:0] ea;
    budget = 0;
    while (in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("ready_before_send", 32'(in_ready), 32'd1);
    exp_done = NE + 1;
    for (int i = 0; i < NE; i++) if (m[i]) exp_done += st[i];
    in_valid     = 1'b1;
    in_vector    = v;
    in_base_addr = b;
`ifdef VEC_WB_MASK_EN
    in_mask      = m;
`endif
    mem_ack      = 1'($urandom_range(0, 1));
    @(negedge clk);
    cyc  = 1;
    li   = 0;
    sl   = 0;
    acks = 0;
    in_vector    = rand_vec();
    in_base_addr = AW'($urandom);
    while (li < NE) begin
      ea = b + AW'(li);
      check("busy_ready", 32'(in_ready), 32'd0);
      check("busy_done", 32'(done), 32'd0);
      if (m[li]) begin
        check("we", 32'(mem_we), 32'd1);
        check("addr", 32'(mem_addr), 32'(ea));
        check("wdata", 32'(mem_wdata), 32'(v[li*E +: E]));
        if (sl < st[li]) begin
          mem_ack = 1'b0;
          sl++;
        end else begin
          mem_ack = 1'b1;
          sl = 0;
          li++;
          acks++;
        end
      end else begin
        check("masked_we", 32'(mem_we), 32'd0);
        mem_ack = 1'($urandom_range(0, 1));
        li++;
      end
      if (abort_after > 0 && acks == abort_after) begin
        @(negedge clk);
        check("pre_abort_addr", 32'(mem_addr), 32'(b + AW'(li)));
        rst      = 1'b1;
        in_valid = 1'b0;
        mem_ack  = 1'b0;
        @(negedge clk);
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_done", 32'(done), 32'd0);
        check("post_abort_we", 32'(mem_we), 32'd0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("done_cycle", 32'(cyc), 32'(exp_done));
    check("done_we", 32'(mem_we), 32'd0);
    check("done_ready", 32'(in_ready), 32'd0);
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("after_ready", 32'(in_ready), 32'd1);
    check("after_done", 32'(done), 32'd0);
    check("after_we", 32'(mem_we), 32'd0);
  endtask

  initial begin
    logic [VS-1:0] v;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_vector    = '0;
    in_base_addr = '0;
`ifdef VEC_WB_MASK_EN
    in_mask      = '1;
`endif
    mem_ack      = 1'b0;
    clear_stalls();

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // idle without valid: nothing captured, stray acks ignored
    for (int k = 0; k < 3; k++) begin
      mem_ack   = 1'b1;
      in_vector = rand_vec();
      @(negedge clk);
      check("idle_ready", 32'(in_ready), 32'd1);
      check("idle_we", 32'(mem_we), 32'd0);
    end

    // lane i = 0x0100+i, base 0x0040, no stalls
    for (int i = 0; i < NE; i++) v[i*E +: E] = E'(16'h0100 + i);
    xfer(v, 16'h0040, '1, 0);

    // same with 3 stall cycles at lane 5
    st[5] = 3;
    xfer(v, 16'h0040, '1, 0);
    clear_stalls();

    // address wrap
    xfer(rand_vec(), 16'hFFF8, '1, 0);

    // reset after the 4th ack, then a fresh vector
    xfer(rand_vec(), 16'h1234, '1, 4);
    xfer(rand_vec(), 16'h0200, '1, 0);

    // random vectors, bases and stalls
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NE; i++) st[i] = int'($urandom_range(0, 2));
      xfer(rand_vec(), AW'($urandom), '1, 0);
    end
    clear_stalls();

`ifdef VEC_WB_MASK_EN
    xfer(rand_vec(), 16'h0300, 16'h00FF, 0);
    xfer(rand_vec(), 16'h0400, 16'h0000, 0);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NE; i++) st[i] = int'($urandom_range(0, 2));
      xfer(rand_vec(), AW'($urandom), NE'($urandom), 0);
    end
    clear_stalls();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
